// File: rtl/fp_issue_scheduler.sv
// FP issue scheduler: tracks in-flight FP ops by destination and completion time,
// stalls on RAW/WAW/writeback-port hazards, and drives forwarding selects and the wb stream.
module fp_issue_scheduler #(
    parameter int unsigned ADD_LAT = 5,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 5,
    parameter int unsigned MAX_LAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [6:0] op_code,
    input  logic [6:0] func7,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic       wb_en,
    output logic       issue_ready,
    output logic [1:0] unit_sel,
    output logic       sub,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic [3:0] inflight_cnt,
    output logic       illegal_op
);

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned LW = $clog2(MAX_LAT + 1);

    localparam logic [6:0] OP_FP  = 7'b1010011;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0000100;
    localparam logic [6:0] F7_MUL = 7'b0001000;
    localparam logic [6:0] F7_DIV = 7'b0001100;

    localparam logic [LW-1:0] ADD_L = LW'(ADD_LAT);
    localparam logic [LW-1:0] MUL_L = LW'(MUL_LAT);
    localparam logic [LW-1:0] DIV_L = LW'(DIV_LAT);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
    } entry_t;

    // slot[k] holds the op whose result reaches the unit output in k cycles
    entry_t        slot_q [MAX_LAT+1];
    entry_t        slot_d [MAX_LAT+1];
    entry_t        mem_slot_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic          is_opfp;
    logic          legal;
    logic          new_entry;
    logic          fire;
    logic [1:0]    unit_c;
    logic          sub_c;
    logic [LW-1:0] lat;
    logic          raw_a;
    logic          raw_b;
    logic          waw;
    logic          struct_stall;

    // Opcode/func7 decode
    always_comb begin
        is_opfp = (op_code == OP_FP);
        legal   = 1'b1;
        unit_c  = 2'b00;
        sub_c   = 1'b0;
        lat     = ADD_L;
        case (func7)
            F7_ADD: ;
            F7_SUB: sub_c = 1'b1;
            F7_MUL: begin
                unit_c = 2'b01;
                lat    = MUL_L;
            end
            F7_DIV: begin
                unit_c = 2'b10;
                lat    = DIV_L;
            end
            default: legal = 1'b0;
        endcase
        new_entry = is_opfp && legal && wb_en;
    end

    // Hazard detection and forwarding selects
    always_comb begin
        raw_a = 1'b0;
        raw_b = 1'b0;
        waw   = 1'b0;
        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            if (slot_q[k].valid) begin
                if (slot_q[k].rd == rs1) raw_a = 1'b1;
                if (slot_q[k].rd == rs2) raw_b = 1'b1;
                if (slot_q[k].rd == rd)  waw   = 1'b1;
            end
        end
        raw_a        = raw_a && rs1_used;
        raw_b        = raw_b && rs2_used;
        struct_stall = slot_q[lat].valid;

        fwd_a_sel = 2'b00;
        if (rs1_used && !raw_a) begin
            if (slot_q[0].valid && slot_q[0].rd == rs1)          fwd_a_sel = 2'b01;
            else if (mem_slot_q.valid && mem_slot_q.rd == rs1)   fwd_a_sel = 2'b10;
        end
        fwd_b_sel = 2'b00;
        if (rs2_used && !raw_b) begin
            if (slot_q[0].valid && slot_q[0].rd == rs2)          fwd_b_sel = 2'b01;
            else if (mem_slot_q.valid && mem_slot_q.rd == rs2)   fwd_b_sel = 2'b10;
        end

        // Illegal OP-FP ops are consumed unconditionally so the trap can be raised
        if (is_opfp && !legal) begin
            issue_ready = 1'b1;
        end else begin
            issue_ready = !(raw_a || raw_b || (new_entry && (waw || struct_stall)));
        end
        fire       = issue_valid && issue_ready;
        unit_sel   = (fire && is_opfp) ? unit_c : 2'b00;
        sub        = fire && is_opfp && legal && sub_c;
        illegal_op = fire && is_opfp && !legal;
    end

    // Next table contents: shift toward slot 0, insert the issuing op
    always_comb begin
        for (int unsigned k = 0; k < MAX_LAT; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        slot_d[MAX_LAT] = '0;
        if (fire && new_entry) begin
            slot_d[lat - LW'(1)] = '{valid: 1'b1, rd: rd};
        end
        cnt_d = '0;
        for (int unsigned k = 0; k <= MAX_LAT; k++) begin
            cnt_d = cnt_d + CW'(slot_d[k].valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                slot_q[k] <= '0;
            end
            mem_slot_q <= '0;
            cnt_q      <= '0;
        end else begin
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
            mem_slot_q <= slot_q[0];
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid     = slot_q[0].valid;
    assign wb_rd        = slot_q[0].rd;
    assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Self-checking bench for fp_issue_scheduler: scenario tasks plus a writeback scoreboard.
module tb_fp_issue_scheduler;

    localparam int unsigned ADD_LAT = 5;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 8;
    localparam int unsigned MAX_LAT = 8;

    localparam logic [6:0] OP_FP  = 7'b1010011;
    localparam logic [6:0] OP_LD  = 7'b0000111;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0000100;
    localparam logic [6:0] F7_MUL = 7'b0001000;
    localparam logic [6:0] F7_DIV = 7'b0001100;
    localparam logic [6:0] F7_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [6:0] op_code;
    logic [6:0] func7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       wb_en;
    logic       issue_ready;
    logic [1:0] unit_sel;
    logic       sub;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [3:0] inflight_cnt;
    logic       illegal_op;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    fp_issue_scheduler #(
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .MAX_LAT(MAX_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .op_code(op_code),
        .func7(func7),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .rs1_used(rs1_used),
        .rs2_used(rs2_used),
        .wb_en(wb_en),
        .issue_ready(issue_ready),
        .unit_sel(unit_sel),
        .sub(sub),
        .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .inflight_cnt(inflight_cnt),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned lat_of(input logic [6:0] f7);
        case (f7)
            F7_ADD, F7_SUB: return ADD_LAT;
            F7_MUL:         return MUL_LAT;
            F7_DIV:         return DIV_LAT;
            default:        return 0;
        endcase
    endfunction

    // Writeback monitor: every completion must match the scoreboard head in cycle and rd
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL wb_missing: cycle %0d no wb for rd=%0d due at %0d", cyc, sb[0].rd, sb[0].cyc);
                void'(sb.pop_front());
            end
            checks++;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                if (wb_valid !== 1'b1 || wb_rd !== sb[0].rd) begin
                    failures++;
                    $display("FAIL wb_order: cycle %0d got valid=%b rd=%0d want valid=1 rd=%0d",
                             cyc, wb_valid, wb_rd, sb[0].rd);
                end
                void'(sb.pop_front());
            end else if (wb_valid !== 1'b0) begin
                failures++;
                $display("FAIL wb_unexpected: cycle %0d got valid=%b rd=%0d want valid=0", cyc, wb_valid, wb_rd);
            end
        end
    end

    task automatic drive(input logic v, input logic [6:0] opc, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                         input logic ua, input logic ub, input logic w);
        issue_valid = v;
        op_code     = opc;
        func7       = f7;
        rd          = d;
        rs1         = a;
        rs2         = b;
        rs1_used    = ua;
        rs2_used    = ub;
        wb_en       = w;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, OP_FP, F7_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Record a firing tracked op in the scoreboard, then advance to the next cycle
    task automatic end_cycle();
        int unsigned l;
        l = lat_of(func7);
        if (issue_valid && issue_ready && op_code == OP_FP && wb_en && l != 0) begin
            sb.push_back('{cyc: cyc + l, rd: rd});
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        idle();
        while ((sb.size() != 0 || inflight_cnt != 4'd0) && n < 60) begin
            end_cycle();
            idle();
            n++;
        end
        checks++;
        if (sb.size() != 0 || inflight_cnt !== 4'd0) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d inflight=%0d want 0/0", sb.size(), inflight_cnt);
        end
        end_cycle();
        idle();
        end_cycle();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || inflight_cnt !== 4'd0 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: wb_valid=%b wb_rd=%0d inflight=%0d illegal=%b want 0/0/0/0",
                     wb_valid, wb_rd, inflight_cnt, illegal_op);
        end
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || unit_sel !== 2'b00 || sub !== 1'b0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: fwd_a=%b fwd_b=%b unit=%b sub=%b ready=%b want 00/00/00/0/1",
                     fwd_a_sel, fwd_b_sel, unit_sel, sub, issue_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        idle();
    endtask

    task automatic test_pipelined();
        int peak;
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, OP_FP, F7_ADD, 5'(i + 1), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (issue_ready !== 1'b1 || unit_sel !== 2'b00 || sub !== 1'b0) begin
                failures++;
                $display("FAIL pipe_issue[%0d]: ready=%b unit=%b sub=%b want 1/00/0", i, issue_ready, unit_sel, sub);
            end
            if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
            end_cycle();
        end
        for (int i = 0; i < 8; i++) begin
            idle();
            if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
            end_cycle();
        end
        checks++;
        if (peak != 5) begin
            failures++;
            $display("FAIL pipe_peak: inflight peak=%0d want 5", peak);
        end
        wait_idle();
    endtask

    task automatic test_units();
        drive(1'b1, OP_FP, F7_SUB, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (issue_ready !== 1'b1 || unit_sel !== 2'b00 || sub !== 1'b1) begin
            failures++;
            $display("FAIL unit_sub: ready=%b unit=%b sub=%b want 1/00/1", issue_ready, unit_sel, sub);
        end
        end_cycle();
        drive(1'b1, OP_FP, F7_MUL, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (issue_ready !== 1'b1 || unit_sel !== 2'b01 || sub !== 1'b0) begin
            failures++;
            $display("FAIL unit_mul: ready=%b unit=%b sub=%b want 1/01/0", issue_ready, unit_sel, sub);
        end
        end_cycle();
        drive(1'b1, OP_FP, F7_DIV, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (issue_ready !== 1'b1 || unit_sel !== 2'b10 || sub !== 1'b0) begin
            failures++;
            $display("FAIL unit_div: ready=%b unit=%b sub=%b want 1/10/0", issue_ready, unit_sel, sub);
        end
        end_cycle();
        wait_idle();
    endtask

    task automatic test_raw();
        drive(1'b1, OP_FP, F7_ADD, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        end_cycle();
        for (int j = 1; j <= 4; j++) begin
            drive(1'b1, OP_FP, F7_MUL, 5'd9, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1);
            checks++;
            if (issue_ready !== 1'b0) begin
                failures++;
                $display("FAIL raw_stall[t0+%0d]: ready=%b want 0", j, issue_ready);
            end
            end_cycle();
        end
        drive(1'b0, OP_FP, F7_MUL, 5'd9, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1);
        checks++;
        if (issue_ready !== 1'b1 || fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL raw_fwd_ex: ready=%b fwd_a=%b fwd_b=%b want 1/01/00", issue_ready, fwd_a_sel, fwd_b_sel);
        end
        end_cycle();
        drive(1'b1, OP_FP, F7_MUL, 5'd9, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1);
        checks++;
        if (issue_ready !== 1'b1 || fwd_a_sel !== 2'b10) begin
            failures++;
            $display("FAIL raw_fwd_mem: ready=%b fwd_a=%b want 1/10", issue_ready, fwd_a_sel);
        end
        end_cycle();
        drive(1'b0, OP_FP, F7_MUL, 5'd9, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1);
        checks++;
        if (fwd_a_sel !== 2'b00) begin
            failures++;
            $display("FAIL raw_fwd_rf: fwd_a=%b want 00", fwd_a_sel);
        end
        end_cycle();
        wait_idle();
    endtask

    task automatic test_structural();
        drive(1'b1, OP_FP, F7_DIV, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        end_cycle();
        idle();
        end_cycle();
        idle();
        end_cycle();
        drive(1'b1, OP_FP, F7_ADD, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL struct_stall: ready=%b want 0", issue_ready);
        end
        end_cycle();
        drive(1'b1, OP_FP, F7_ADD, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL struct_issue: ready=%b want 1", issue_ready);
        end
        end_cycle();
        wait_idle();
    endtask

    task automatic test_waw();
        drive(1'b1, OP_FP, F7_DIV, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        end_cycle();
        for (int j = 1; j <= 8; j++) begin
            drive(1'b1, OP_FP, F7_ADD, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (issue_ready !== (j == 8)) begin
                failures++;
                $display("FAIL waw[t0+%0d]: ready=%b want %b", j, issue_ready, (j == 8));
            end
            end_cycle();
        end
        wait_idle();
    endtask

    task automatic test_non_fp();
        drive(1'b1, OP_FP, F7_ADD, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        end_cycle();
        drive(1'b1, OP_LD, F7_ADD, 5'd20, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1);
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL nonfp_raw: ready=%b want 0", issue_ready);
        end
        drive(1'b1, OP_LD, F7_ADD, 5'd20, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL nonfp_unused: ready=%b want 1", issue_ready);
        end
        end_cycle();
        drive(1'b1, OP_FP, F7_ADD, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (issue_ready !== 1'b1 || inflight_cnt !== 4'd1) begin
            failures++;
            $display("FAIL nowb_issue: ready=%b inflight=%0d want 1/1", issue_ready, inflight_cnt);
        end
        end_cycle();
        idle();
        checks++;
        if (inflight_cnt !== 4'd1) begin
            failures++;
            $display("FAIL nowb_no_entry: inflight=%0d want 1", inflight_cnt);
        end
        end_cycle();
        wait_idle();
    endtask

    task automatic test_illegal_reset();
        drive(1'b1, OP_FP, F7_ADD, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        end_cycle();
        drive(1'b1, OP_FP, F7_BAD, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (issue_ready !== 1'b1 || illegal_op !== 1'b1 || unit_sel !== 2'b00 || inflight_cnt !== 4'd1) begin
            failures++;
            $display("FAIL illegal: ready=%b illegal=%b unit=%b inflight=%0d want 1/1/00/1",
                     issue_ready, illegal_op, unit_sel, inflight_cnt);
        end
        end_cycle();
        drive(1'b1, OP_FP, F7_ADD, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (illegal_op !== 1'b0 || inflight_cnt !== 4'd1) begin
            failures++;
            $display("FAIL illegal_after: illegal=%b inflight=%0d want 0/1", illegal_op, inflight_cnt);
        end
        end_cycle();
        idle();
        end_cycle();
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (inflight_cnt !== 4'd0 || wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: inflight=%0d wb_valid=%b ready=%b want 0/0/1", inflight_cnt, wb_valid, issue_ready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            idle();
            end_cycle();
        end
        idle();
        checks++;
        if (inflight_cnt !== 4'd0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: inflight=%0d ready=%b want 0/1", inflight_cnt, issue_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_pipelined();
        test_units();
        test_raw();
        test_structural();
        test_waw();
        test_non_fp();
        test_illegal_reset();
        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_issue_scheduler.md
# fp_issue_scheduler

Issue scheduler for the floating-point execute stage. Sits between FP decode and the FP add/mul/div units. Tracks every in-flight FP operation by destination register and cycles-to-completion, and stalls issue on RAW, WAW and writeback-port hazards. Generates forwarding selects for the EX operand muxes and replaces per-op control delay chains with a single ordered completion stream (wb_valid/wb_rd) for the MEM stage.

## Interface
- ADD_LAT, 5, cycles from issue to result for FADD/FSUB (1..MAX_LAT)
- MUL_LAT, 5, cycles from issue to result for FMUL (1..MAX_LAT)
- DIV_LAT, 5, cycles from issue to result for FDIV (1..MAX_LAT)
- MAX_LAT, 8, depth of completion table; upper bound of all latencies

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decoded FP-side instruction presented
- op_code  in  7  opcode; 7'b1010011 = OP-FP
- func7  in  7  0000000 add, 0000100 sub, 0001000 mul, 0001100 div
- rd, rs1, rs2  in  5 each  register indices
- rs1_used, rs2_used  in  1 each  source read by this instruction
- wb_en  in  1  instruction writes an FP register
- issue_ready  out  1  combinational; instruction may issue this cycle
- unit_sel  out  2  00 add, 01 mul, 10 div; valid when issue fires
- sub  out  1  high for FSUB issue
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 unit result (EX out), 10 MEM-stage result
- wb_valid  out  1  a tracked result completes this cycle
- wb_rd  out  5  destination of completing result
- inflight_cnt  out  4  number of valid table entries
- illegal_op  out  1  one-cycle pulse on unsupported func7 with OP-FP

## Operation
- Table slot[0..MAX_LAT], each {valid, rd}; index = cycles until result appears at unit output. mem_slot {valid, rd} holds the entry one cycle after slot[0].
- Every clock: slot[k] <= slot[k+1]; slot[MAX_LAT] <= invalid; mem_slot <= slot[0].
- Issue fires when issue_valid && issue_ready. OP-FP with legal func7 and wb_en=1: write {1, rd} into slot[L-1], L = latency of selected unit. This overrides the shifted value; a stall rule guarantees that slot is empty.
- Non-OP-FP, or wb_en=0: hazard-checked on sources only; no entry.
- Illegal func7 with OP-FP: issue_ready=1, illegal_op pulses, no entry, unit_sel=00.
- Source hazard for rsN with rsN_used (rd/rs 0 included; FP f0 is a real register):
  - match in any slot[k], k>=1 -> stall;
  - else match slot[0] -> fwd 01;
  - else match mem_slot -> fwd 10;
  - else 00.
- WAW: a new entry whose rd matches any slot[k], k>=1 -> stall.
- Structural: single writeback port. The new entry stalls if slot[L] is valid, because it would shift into slot[L-1].
- issue_ready = !(RAW stall || WAW stall || structural stall). fwd selects are driven even when not firing.
- Completions are never cancelled. Exactly one wb per cycle max; wb order equals completion time.

## Timing
- Reset: all slots and mem_slot invalid. Outputs wb_valid=0, wb_rd=0, inflight_cnt=0, illegal_op=0, fwd selects 00, unit_sel 00, sub 0. issue_ready=1 with empty table.
- Op issued at cycle t with latency L: wb_valid=1, wb_rd=rd at cycle t+L. Its result is forwardable with sel 01 at t+L and sel 10 at t+L+1.
- Minimum dependent issue distance = L cycles, using fwd 01.
- rst mid-operation clears all entries immediately. No wb_valid follows for ops issued before reset.
- Back-to-back independent same-latency ops issue every cycle with no stall.

## Test plan
- Pipelined adds: 10 consecutive independent FADDs rd=1..10 at t0..t0+9 -> issue_ready stays 1; wb_valid at t0+5..t0+14 with wb_rd 1..10; inflight_cnt peaks at 5.
- RAW: FADD rd=3 at t0, then FMUL rs1=3 held -> issue_ready=0 for t0+1..t0+4. At t0+5, issue_ready=1 and fwd_a_sel=01. The same instruction held to t0+6 shows fwd_a_sel=10.
- Structural (DIV_LAT=8): FDIV rd=2 at t0, FADD rd=4 presented at t0+3 -> stalled at t0+3, issues t0+4; wb_rd=2 at t0+8, wb_rd=4 at t0+9.
- WAW (DIV_LAT=8): FDIV rd=5 at t0, FADD rd=5 presented at t0+1 -> stalled through t0+7, issues t0+8; wb_rd=5 at t0+8 and t0+13.
- Illegal/reset: OP-FP func7=7'b1111111 -> illegal_op pulse, inflight_cnt unchanged. Then FADD rd=7, rst asserted at +2 cycles -> inflight_cnt=0, no wb_valid afterward, issue_ready=1.
